inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Instruction-fetch front end that sits between the instruction ROM (inst_rom) and the decode stage of top_cpu.
- Owns the PC and drives the ROM address and chip-enable.
- Buffers fetched {pc, inst} pairs in a small FIFO so decode stalls do not stop fetching.
- Handles taken-branch redirects by flushing the FIFO and reloading the PC.

Parameters:
- QUEUE_DEPTH, 4, number of buffered {pc, inst} entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rom_addr_out  out  32  fetch address to inst_rom
- rom_ce_o  out  1  ROM chip-enable; a fetch is issued in every cycle this is 1
- rom_data_inst  in  32  ROM read data; combinational, valid in the same cycle as rom_addr_out when rom_ce_o=1
- branch_flag_i  in  1  taken-branch redirect request from execute
- branch_target_i  in  32  redirect address
- id_ready_i  in  1  decode accepts the head entry this cycle
- id_valid_o  out  1  head entry valid
- id_pc_o  out  32  PC of head entry
- id_inst_o  out  32  instruction of head entry
- q_count_o  out  3  current occupancy, 0..QUEUE_DEPTH (width = log2(QUEUE_DEPTH)+1)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State machine: S_RESET, S_RUN.
  - rst=1 forces S_RESET.
  - S_RESET moves to S_RUN on the first edge with rst=0.
  - S_RUN stays in S_RUN until rst.
- Registers:
  - fetch_pc (32)
  - FIFO arrays pc_q/inst_q[QUEUE_DEPTH]
  - rd_ptr, wr_ptr (log2 depth, wrap modulo QUEUE_DEPTH)
  - count
- Reset values (also in the cycle rst is sampled):
  - fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0, state=S_RESET.
  - Outputs: rom_ce_o=0, rom_addr_out=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0, q_count_o=0.
  - rst asserted mid-operation discards all queued entries and any redirect on the next edge.
- rom_addr_out = fetch_pc (registered), always.
- rom_ce_o = (state==S_RUN) && (count < QUEUE_DEPTH).
  - Does not depend on id_ready_i: a full queue blocks fetch even if a pop occurs that cycle.
- Push: when rom_ce_o=1 and branch_flag_i=0:
  - write {fetch_pc, rom_data_inst} at wr_ptr;
  - wr_ptr++;
  - fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0).
- Pop: when id_valid_o=1 and id_ready_i=1, rd_ptr++.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- id_valid_o = (count != 0) && !branch_flag_i.
  - id_pc_o/id_inst_o = head entry (pc_q/inst_q[rd_ptr]) when count != 0, else 0.
  - Combinational from registered state plus branch_flag_i: zero-latency head visibility.
- Latency: an instruction fetched at edge N is visible on id_* in the cycle after edge N; minimum 1 cycle ROM-to-decode.
- Redirect: branch_flag_i=1 in S_RUN:
  - at the edge: count=0, rd_ptr=wr_ptr=0, fetch_pc = {branch_target_i[31:2], 2'b00};
  - no push and no pop that cycle, even if rom_ce_o=1 and id_ready_i=1;
  - first target fetch occurs the following cycle;
  - branch_flag_i in S_RESET or with rst=1 is ignored.
- Back-to-back redirects: each cycle reloads fetch_pc; the last one wins.
- Empty with id_ready_i=1: no pop, count stays 0.
- Full (count==QUEUE_DEPTH): rom_ce_o=0, fetch_pc holds; resumes the cycle after count drops.
- Misaligned target: low 2 bits silently cleared; no error output.

Test Plan:
- Reset then stream: rst=1 for 2 cycles, then rst=0, id_ready_i=1; ROM returns 32'h1000_0000+addr.
  - Cycle 0: rom_ce_o=0.
  - Then rom_addr_out steps 0,4,8...
  - id_valid_o first high 2 cycles after deassert with id_pc_o=0, id_inst_o=32'h1000_0000; then one instruction per cycle in order.
- Backpressure fill: id_ready_i=0 from reset.
  - After 4 fetches q_count_o=4, rom_ce_o=0, rom_addr_out=16 holds.
  - Raise id_ready_i: pops in order pc 0,4,8,12; rom_ce_o returns to 1 the cycle after the first pop.
- Redirect flush: stream with queue holding 3 entries; pulse branch_flag_i with branch_target_i=32'h0000_0103.
  - id_valid_o=0 that cycle, q_count_o=0 next cycle.
  - rom_addr_out=32'h0000_0100; next id_pc_o=32'h100. No stale pc ever reaches decode.
- Simultaneous push/pop at count=2 with id_ready_i=1: q_count_o stays 2 every cycle; output pc sequence is contiguous +4.
- PC wrap: redirect to 32'hFFFF_FFF8; subsequent fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset mid-run: assert rst with q_count_o=3 and branch_flag_i=1 in the same cycle.
  - Next cycle all outputs are at reset values, rom_addr_out=RESET_PC.
  - Restarts from RESET_PC after deassert.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives inst_rom, and buffers
// fetched {pc, inst} pairs for decode; taken branches flush and redirect.

module ifq_entry (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] pc_d,
  input  logic [31:0] inst_d,
  output logic [31:0] pc_q,
  output logic [31:0] inst_q
);

  // Storage only; validity is tracked by the queue count, so no reset needed.
  always_ff @(posedge clk) begin
    if (we) begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
    end
  end

endmodule

module inst_fetch_queue #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [31:0]                  rom_addr_out,
  output logic                         rom_ce_o,
  input  logic [31:0]                  rom_data_inst,
  input  logic                         branch_flag_i,
  input  logic [31:0]                  branch_target_i,
  input  logic                         id_ready_i,
  output logic                         id_valid_o,
  output logic [31:0]                  id_pc_o,
  output logic [31:0]                  id_inst_o,
  output logic [$clog2(QUEUE_DEPTH):0] q_count_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  localparam logic [0:0] S_RESET = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]       state;
  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic [QUEUE_DEPTH-1:0][31:0] pc_arr, inst_arr;
  logic [QUEUE_DEPTH-1:0]       ent_we;

  logic run, redirect, push, pop, has_data;

  // Outputs are forced to reset values in the same cycle rst is sampled.
  assign run      = (state == S_RUN) && !rst;
  assign has_data = (count != '0) && !rst;
  assign redirect = run && branch_flag_i;
  assign rom_ce_o = run && (count != FULL_CNT);
  assign push     = rom_ce_o && !branch_flag_i;
  assign pop      = id_valid_o && id_ready_i;

  assign rom_addr_out = fetch_pc;
  assign id_valid_o   = has_data && !branch_flag_i;
  assign id_pc_o      = has_data ? pc_arr[rd_ptr]   : 32'h0;
  assign id_inst_o    = has_data ? inst_arr[rd_ptr] : 32'h0;
  assign q_count_o    = rst ? '0 : count;

  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_ent
      assign ent_we[gi] = push && (wr_ptr == PTR_W'(gi));
      ifq_entry u_ent (
        .clk    (clk),
        .we     (ent_we[gi]),
        .pc_d   (fetch_pc),
        .inst_d (rom_data_inst),
        .pc_q   (pc_arr[gi]),
        .inst_q (inst_arr[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= S_RUN;
      if (redirect) begin
        // Flush wins over any push/pop; low two bits of the target dropped.
        fetch_pc <= branch_target_i & ~32'h3;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue; ROM model returns 32'h1000_0000 + addr.

module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr_out;
  logic        rom_ce_o;
  logic [31:0] rom_data_inst;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [2:0]  q_count_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_data_inst = 32'h1000_0000 + rom_addr_out;

  inst_fetch_queue #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_addr_out    (rom_addr_out),
    .rom_ce_o        (rom_ce_o),
    .rom_data_inst   (rom_data_inst),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .id_ready_i      (id_ready_i),
    .id_valid_o      (id_valid_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .q_count_o       (q_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are changed afterwards.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".ce"},    {31'h0, rom_ce_o},   32'h0);
    chk({tag, ".addr"},  rom_addr_out,        32'h0);
    chk({tag, ".valid"}, {31'h0, id_valid_o}, 32'h0);
    chk({tag, ".pc"},    id_pc_o,             32'h0);
    chk({tag, ".inst"},  id_inst_o,           32'h0);
    chk({tag, ".cnt"},   {29'h0, q_count_o},  32'h0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
    chk({tag, ".valid"}, {31'h0, id_valid_o}, 32'h1);
    chk({tag, ".pc"},    id_pc_o,             pc);
    chk({tag, ".inst"},  id_inst_o,           32'h1000_0000 + pc);
    chk({tag, ".cnt"},   {29'h0, q_count_o},  {29'h0, cnt});
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1; branch_flag_i = 1'b0; branch_target_i = '0; id_ready_i = ready;
    edge1();
    #1 chk_reset_outs("rst0");
    edge1();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset then stream
    do_reset(1'b1);
    chk("stream.c0.ce", {31'h0, rom_ce_o}, 32'h0);
    edge1(); #1;
    chk("stream.c1.ce",    {31'h0, rom_ce_o},   32'h1);
    chk("stream.c1.addr",  rom_addr_out,        32'h0);
    chk("stream.c1.valid", {31'h0, id_valid_o}, 32'h0);
    chk("stream.c1.cnt",   {29'h0, q_count_o},  32'h0);
    for (int k = 0; k < 4; k++) begin
      edge1(); #1;
      chk_head($sformatf("stream.h%0d", k), 32'(4 * k), 3'd1);
      chk($sformatf("stream.a%0d", k), rom_addr_out, 32'(4 * k + 4));
    end

    // Backpressure fill
    do_reset(1'b0);
    repeat (5) edge1();
    #1;
    chk("fill.cnt",  {29'h0, q_count_o}, 32'h4);
    chk("fill.ce",   {31'h0, rom_ce_o},  32'h0);
    chk("fill.addr", rom_addr_out,       32'h10);
    edge1(); #1;
    chk("fill.hold.addr", rom_addr_out, 32'h10);
    id_ready_i = 1'b1;
    #1;
    chk_head("fill.p0", 32'h0, 3'd4);
    chk("fill.p0.ce", {31'h0, rom_ce_o}, 32'h0);
    edge1(); #1;
    chk_head("fill.p1", 32'h4, 3'd3);
    chk("fill.p1.ce",   {31'h0, rom_ce_o}, 32'h1);
    chk("fill.p1.addr", rom_addr_out,      32'h10);
    edge1(); #1;
    chk_head("fill.p2", 32'h8, 3'd3);
    edge1(); #1;
    chk_head("fill.p3", 32'hC, 3'd3);
    edge1(); #1;
    chk_head("fill.p4", 32'h10, 3'd3);

    // Redirect flush with 3 entries queued
    branch_flag_i = 1'b1; branch_target_i = 32'h0000_0103;
    #1;
    chk("br.valid", {31'h0, id_valid_o}, 32'h0);
    edge1();
    branch_flag_i = 1'b0;
    #1;
    chk("br.cnt",   {29'h0, q_count_o},  32'h0);
    chk("br.addr",  rom_addr_out,        32'h100);
    chk("br.valid2", {31'h0, id_valid_o}, 32'h0);
    edge1(); #1;
    chk_head("br.h", 32'h100, 3'd1);
    chk("br.addr2", rom_addr_out, 32'h104);

    // Simultaneous push/pop at count 2
    id_ready_i = 1'b0;
    edge1(); #1;
    chk_head("pp.fill", 32'h100, 3'd2);
    id_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      edge1(); #1;
      chk_head($sformatf("pp.h%0d", k), 32'(32'h100 + 4 * k), 3'd2);
    end

    // PC wrap
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFF8;
    edge1();
    branch_flag_i = 1'b0;
    #1;
    chk("wrap.a0", rom_addr_out, 32'hFFFF_FFF8);
    edge1(); #1;
    chk("wrap.a1", rom_addr_out, 32'hFFFF_FFFC);
    chk_head("wrap.h0", 32'hFFFF_FFF8, 3'd1);
    edge1(); #1;
    chk("wrap.a2", rom_addr_out, 32'h0);
    chk_head("wrap.h1", 32'hFFFF_FFFC, 3'd1);
    edge1(); #1;
    chk("wrap.a3", rom_addr_out, 32'h4);
    chk_head("wrap.h2", 32'h0, 3'd1);

    // Reset mid-run with 3 queued and a redirect in the same cycle
    id_ready_i = 1'b0;
    repeat (2) edge1();
    #1;
    chk("mid.cnt", {29'h0, q_count_o}, 32'h3);
    rst = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h0000_0300; id_ready_i = 1'b1;
    edge1();
    // A redirect in S_RESET must be ignored.
    rst = 1'b0; branch_target_i = 32'h0000_0200;
    #1 chk_reset_outs("mid.rst");
    edge1();
    branch_flag_i = 1'b0;
    #1;
    chk("mid.ce",   {31'h0, rom_ce_o}, 32'h1);
    chk("mid.addr", rom_addr_out,      32'h0);
    edge1(); #1;
    chk_head("mid.h0", 32'h0, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
